mem_port_arbiter: RTL and testbench

// - Shares one 19-bit unified memory port between the instruction-fetch requester (IF) and the load/store requester (D).
// - Sits between instr_mem/data_mem and the external memory.
// - Arbitrates per cycle and issues pipelined accesses, one per cycle.
// - Routes each read response back to the requester that issued it.
// - Raises stall_o for the core while a request waits.

---
 rtl/mem_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 19-bit memory port between instruction fetch
// (IF) and load/store (D). Default build gives D priority, with a starvation
// counter that forces a waiting fetch through after STARVE_MAX denied cycles.
// Defining ARB_ROUND_ROBIN_EN swaps that for a two-way round robin.
// Read responses are routed back to their issuer through a MEM_LAT-deep tag pipe.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req_i,
  input  logic [18:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [18:0] if_rdata_o,
  input  logic        d_req_i,
  input  logic        d_wr_i,
  input  logic [18:0] d_addr_i,
  input  logic [1:0]  d_byte_en_i,
  input  logic [18:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [18:0] d_rdata_o,
  output logic        mem_req_o,
  output logic        mem_wr_o,
  output logic [18:0] mem_addr_o,
  output logic [1:0]  mem_byte_en_o,
  output logic [18:0] mem_wdata_o,
  input  logic [18:0] mem_rdata_i,
  output logic        stall_o
);

  localparam logic OwnerIf = 1'b0;
  localparam logic OwnerD  = 1'b1;

  logic               ifGnt;
  logic               dGnt;
  logic               pushValid;
  logic               pushOwner;
  logic               respValid;
  logic               respOwner;
  logic [MEM_LAT-1:0] tagValid_q;
  logic [MEM_LAT-1:0] tagValid_d;
  logic [MEM_LAT-1:0] tagOwner_q;
  logic [MEM_LAT-1:0] tagOwner_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic lastOwner_q;
  logic lastOwner_d;

  // On a tie the requester that did not win most recently gets the port
  always_comb begin
    ifGnt = 1'b0;
    dGnt  = 1'b0;
    if (!reset) begin
      if (if_req_i && d_req_i) begin
        if (lastOwner_q == OwnerD) begin
          ifGnt = 1'b1;
        end else begin
          dGnt = 1'b1;
        end
      end else begin
        ifGnt = if_req_i;
        dGnt  = d_req_i;
      end
    end
  end

  // Remember who was granted last; idle cycles leave it untouched
  always_comb begin
    lastOwner_d = lastOwner_q;
    if (ifGnt) begin
      lastOwner_d = OwnerIf;
    end else if (dGnt) begin
      lastOwner_d = OwnerD;
    end
  end

  // Round-robin history register, starts out as if IF had just won
  always_ff @(posedge clk) begin
    if (reset) begin
      lastOwner_q <= OwnerIf;
    end else begin
      lastOwner_q <= lastOwner_d;
    end
  end
`else
  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  logic [3:0] starveCnt_q;
  logic [3:0] starveCnt_d;
  logic       starveForce;

  // D wins ties unless the fetch has been refused STARVE_MAX times in a row
  always_comb begin
    starveForce = (starveCnt_q == StarveMax);
    ifGnt       = 1'b0;
    dGnt        = 1'b0;
    if (!reset) begin
      if (if_req_i && (!d_req_i || starveForce)) begin
        ifGnt = 1'b1;
      end else if (d_req_i) begin
        dGnt = 1'b1;
      end
    end
  end

  // Count consecutive refused fetch cycles, saturating at the limit
  always_comb begin
    starveCnt_d = starveCnt_q;
    if (!if_req_i || ifGnt) begin
      starveCnt_d = 4'd0;
    end else if (!starveForce) begin
      starveCnt_d = starveCnt_q + 4'd1;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      starveCnt_q <= 4'd0;
    end else begin
      starveCnt_q <= starveCnt_d;
    end
  end
`endif

  // Drive the shared memory port from whichever requester won this cycle
  always_comb begin
    mem_req_o     = 1'b0;
    mem_wr_o      = 1'b0;
    mem_addr_o    = '0;
    mem_byte_en_o = 2'b00;
    mem_wdata_o   = '0;
    if (ifGnt) begin
      mem_req_o     = 1'b1;
      mem_addr_o    = if_addr_i;
      mem_byte_en_o = 2'b11;
    end else if (dGnt) begin
      mem_req_o     = 1'b1;
      mem_wr_o      = d_wr_i;
      mem_addr_o    = d_addr_i;
      mem_byte_en_o = d_byte_en_i;
      mem_wdata_o   = d_wdata_i;
    end
  end

  // Tag each issue slot; only reads expect data back, so writes push an empty slot
  always_comb begin
    pushValid  = ifGnt | (dGnt & ~d_wr_i);
    pushOwner  = dGnt;
    tagValid_d = (tagValid_q << 1) | MEM_LAT'(pushValid);
    tagOwner_d = (tagOwner_q << 1) | MEM_LAT'(pushOwner);
  end

  // Tag pipe; reset empties it so in-flight reads are never delivered
  always_ff @(posedge clk) begin
    if (reset) begin
      tagValid_q <= '0;
      tagOwner_q <= '0;
    end else begin
      tagValid_q <= tagValid_d;
      tagOwner_q <= tagOwner_d;
    end
  end

  // Steer the returning read data to its owner and zero the other side
  always_comb begin
    respValid   = tagValid_q[MEM_LAT-1] & ~reset;
    respOwner   = tagOwner_q[MEM_LAT-1];
    if_rvalid_o = respValid & (respOwner == OwnerIf);
    d_rvalid_o  = respValid & (respOwner == OwnerD);
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    d_rdata_o   = d_rvalid_o ? mem_rdata_i : '0;
  end

  // Grants and the core stall follow the arbitration result directly
  always_comb begin
    if_gnt_o = ifGnt;
    d_gnt_o  = dGnt;
    stall_o  = ~reset & ((if_req_i & ~ifGnt) | (d_req_i & ~dGnt));
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two arbiters (MEM_LAT 2 and 3) driven by the same
// directed request sequence, each with its own fixed-latency memory model.
// Expected read responses go into a per-instance queue when the request is
// applied and are popped on the cycle they are due.
module tb_mem_port_arbiter;

  localparam logic [18:0] DataKey = 19'h1AACD;
  localparam logic [18:0] Garbage = 19'h2A5A5;

  typedef struct {
    int          due;
    logic        owner;
    logic [18:0] data;
  } resp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifReq;
  logic [18:0] ifAddr;
  logic        dReq;
  logic        dWr;
  logic [18:0] dAddr;
  logic [1:0]  dByteEn;
  logic [18:0] dWdata;

  logic        ifGnt     [2];
  logic        ifRvalid  [2];
  logic [18:0] ifRdata   [2];
  logic        dGnt      [2];
  logic        dRvalid   [2];
  logic [18:0] dRdata    [2];
  logic        memReq    [2];
  logic        memWr     [2];
  logic [18:0] memAddr   [2];
  logic [1:0]  memByteEn [2];
  logic [18:0] memWdata  [2];
  logic [18:0] memRdata  [2];
  logic        stall     [2];

  resp_t q0[$];
  resp_t q1[$];

  int          totalChecks = 0;
  int          badChecks   = 0;
  int          stepNo      = 0;
  logic        ifPending;
  logic        dPending;
  logic [18:0] ifHeldAddr;
  logic [40:0] dHeld;

  // Free-running clock
  always #5 clk = ~clk;

  // One arbiter plus a fixed-latency memory per latency under test
  for (genvar k = 0; k < 2; k++) begin : gLat
    localparam int Lat = k + 2;
    logic        pipeV [Lat];
    logic [18:0] pipeA [Lat];

    mem_port_arbiter #(.MEM_LAT(Lat), .STARVE_MAX(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .if_req_i     (ifReq),
      .if_addr_i    (ifAddr),
      .if_gnt_o     (ifGnt[k]),
      .if_rvalid_o  (ifRvalid[k]),
      .if_rdata_o   (ifRdata[k]),
      .d_req_i      (dReq),
      .d_wr_i       (dWr),
      .d_addr_i     (dAddr),
      .d_byte_en_i  (dByteEn),
      .d_wdata_i    (dWdata),
      .d_gnt_o      (dGnt[k]),
      .d_rvalid_o   (dRvalid[k]),
      .d_rdata_o    (dRdata[k]),
      .mem_req_o    (memReq[k]),
      .mem_wr_o     (memWr[k]),
      .mem_addr_o   (memAddr[k]),
      .mem_byte_en_o(memByteEn[k]),
      .mem_wdata_o  (memWdata[k]),
      .mem_rdata_i  (memRdata[k]),
      .stall_o      (stall[k])
    );

    // Memory model: read data is address XOR key, Lat cycles after issue
    always @(posedge clk) begin
      pipeV[0] <= memReq[k] & ~memWr[k];
      pipeA[0] <= memAddr[k];
      for (int i = 1; i < Lat; i++) begin
        pipeV[i] <= pipeV[i-1];
        pipeA[i] <= pipeA[i-1];
      end
    end

    assign memRdata[k] = pipeV[Lat-1] ? (pipeA[Lat-1] ^ DataKey) : Garbage;
  end

  // Compare one observed value against the expectation and count it
  task automatic checkOutput(input string tag, input int k,
                             input logic [63:0] obs, input logic [63:0] exp);
    totalChecks++;
    assert (obs === exp) else begin
      badChecks++;
      $error("FAIL %s lat=%0d step=%0d observed=%0h expected=%0h",
             tag, k + 2, stepNo, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, check every output, and book expected reads
  task automatic applyStimulus(input logic rst,
                               input logic ifR, input logic [18:0] ifA,
                               input logic dR, input logic dW,
                               input logic [18:0] dA, input logic [1:0] dBe,
                               input logic [18:0] dWd,
                               input logic expIf, input logic expD);
    logic        expStall;
    logic        expMemReq;
    logic        expMemWr;
    logic [18:0] expMemAddr;
    logic [1:0]  expMemBe;
    logic [18:0] expMemWd;
    logic        hit;
    resp_t       head;
    resp_t       entry;

    @(negedge clk);
    reset   = rst;
    ifReq   = ifR;
    ifAddr  = ifA;
    dReq    = dR;
    dWr     = dW;
    dAddr   = dA;
    dByteEn = dBe;
    dWdata  = dWd;
    if (ifPending) checkOutput("ifHold", 0, {ifReq, ifAddr}, {1'b1, ifHeldAddr});
    if (dPending) checkOutput("dHold", 0, {dReq, dWr, dAddr, dByteEn, dWdata}, {1'b1, dHeld});
    #1;

    expStall   = !rst && ((ifR && !expIf) || (dR && !expD));
    expMemReq  = expIf || expD;
    expMemWr   = expD && dW;
    expMemAddr = expIf ? ifA : (expD ? dA : 19'h0);
    expMemBe   = expIf ? 2'b11 : (expD ? dBe : 2'b00);
    expMemWd   = expD ? dWd : 19'h0;

    for (int k = 0; k < 2; k++) begin
      checkOutput("ifGnt", k, ifGnt[k], expIf);
      checkOutput("dGnt", k, dGnt[k], expD);
      checkOutput("stall", k, stall[k], expStall);
      checkOutput("memReq", k, memReq[k], expMemReq);
      checkOutput("memWr", k, memWr[k], expMemWr);
      checkOutput("memAddr", k, memAddr[k], expMemAddr);
      checkOutput("memByteEn", k, memByteEn[k], expMemBe);
      checkOutput("memWdata", k, memWdata[k], expMemWd);

      hit  = 1'b0;
      head = '{due: 0, owner: 1'b0, data: 19'h0};
      if (rst) begin
        if (k == 0) q0.delete();
        else q1.delete();
      end else if (k == 0) begin
        if (q0.size() > 0 && q0[0].due == stepNo) begin
          head = q0.pop_front();
          hit  = 1'b1;
        end
      end else begin
        if (q1.size() > 0 && q1[0].due == stepNo) begin
          head = q1.pop_front();
          hit  = 1'b1;
        end
      end
      checkOutput("ifRvalid", k, ifRvalid[k], hit && !head.owner);
      checkOutput("ifRdata", k, ifRdata[k], (hit && !head.owner) ? head.data : 19'h0);
      checkOutput("dRvalid", k, dRvalid[k], hit && head.owner);
      checkOutput("dRdata", k, dRdata[k], (hit && head.owner) ? head.data : 19'h0);
    end

    if (!rst && (expIf || (expD && !dW))) begin
      entry.owner = expD;
      entry.data  = (expIf ? ifA : dA) ^ DataKey;
      entry.due   = stepNo + 2;
      q0.push_back(entry);
      entry.due   = stepNo + 3;
      q1.push_back(entry);
    end

    ifPending  = !rst && ifR && !expIf;
    ifHeldAddr = ifA;
    dPending   = !rst && dR && !expD;
    dHeld      = {dW, dA, dBe, dWd};
    stepNo++;
  endtask

  // Quiet cycles with no requests, letting responses drain
  task automatic runIdle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 19'h0, 1'b0, 1'b0, 19'h0, 2'b00, 19'h0, 1'b0, 1'b0);
    end
  endtask

  // Directed sequence
  initial begin
    logic expIfWin;
    reset     = 1'b1;
    ifReq     = 1'b0;
    ifAddr    = '0;
    dReq      = 1'b0;
    dWr       = 1'b0;
    dAddr     = '0;
    dByteEn   = '0;
    dWdata    = '0;
    ifPending = 1'b0;
    dPending  = 1'b0;
    $display("[TB] mem_port_arbiter bench starting");

    // Reset, including a cycle with both requests up: nothing may be granted
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 19'h0, 1'b0, 1'b0, 19'h0, 2'b00, 19'h0, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 19'h00111, 1'b1, 1'b0, 19'h00222, 2'b11, 19'h0, 1'b0, 1'b0);

    // T1: single fetch, data 0x1ABCD comes back to IF
    applyStimulus(1'b0, 1'b1, 19'h00100, 1'b0, 1'b0, 19'h0, 2'b00, 19'h0, 1'b1, 1'b0);
    runIdle(4);

    // T2: contention, D first then IF
    applyStimulus(1'b0, 1'b1, 19'h00140, 1'b1, 1'b0, 19'h00200, 2'b11, 19'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 19'h00140, 1'b0, 1'b0, 19'h0, 2'b00, 19'h0, 1'b1, 1'b0);
    runIdle(4);

    // T3: both held for ten cycles
    for (int i = 0; i < 10; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      expIfWin = (i % 2) == 1;
`else
      expIfWin = (i == 4) || (i == 9);
`endif
      applyStimulus(1'b0, 1'b1, 19'h00180, 1'b1, 1'b0, 19'h00220, 2'b11, 19'h0,
                    expIfWin, !expIfWin);
    end
    applyStimulus(1'b0, 1'b0, 19'h0, 1'b1, 1'b0, 19'h00220, 2'b11, 19'h0, 1'b0, 1'b1);
    runIdle(4);

    // T4: write forwards its payload and never produces a response
    applyStimulus(1'b0, 1'b0, 19'h0, 1'b1, 1'b1, 19'h00300, 2'b01, 19'h0005A, 1'b0, 1'b1);
    runIdle(4);

    // T5: reset one cycle after a fetch issues; the fetch data must be dropped
    applyStimulus(1'b0, 1'b1, 19'h00400, 1'b0, 1'b0, 19'h0, 2'b00, 19'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 19'h0, 1'b0, 1'b0, 19'h0, 2'b00, 19'h0, 1'b0, 1'b0);
    runIdle(3);
    applyStimulus(1'b0, 1'b1, 19'h00440, 1'b1, 1'b0, 19'h00500, 2'b11, 19'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 19'h00440, 1'b0, 1'b0, 19'h0, 2'b00, 19'h0, 1'b1, 1'b0);
    runIdle(4);

    // T6: six alternating back-to-back reads
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        applyStimulus(1'b0, 1'b1, 19'h00600 + 19'(i), 1'b0, 1'b0, 19'h0, 2'b00, 19'h0,
                      1'b1, 1'b0);
      end else begin
        applyStimulus(1'b0, 1'b0, 19'h0, 1'b1, 1'b0, 19'h00700 + 19'(i), 2'b11, 19'h0,
                      1'b0, 1'b1);
      end
    end
    runIdle(5);

    // Every booked response must have been delivered
    checkOutput("sbDrain", 0, 64'(q0.size()), 64'd0);
    checkOutput("sbDrain", 1, 64'(q1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
